// File: rtl/gor_ex_pkg.sv
// gor_ex_pkg: shared types and constants for the gor_exerciser self-test block.
//   state_t    : sequencer state (IDLE, RUN, DONE)
//   NUM_VECS   : vectors per sweep of the 2-input gate
//   ERR_W      : width of the saturating mismatch counter
//   VEC_ORDER  : {a,b} drive order within one sweep
//   vec_at()   : table lookup by vector index
package gor_ex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECS = 4;
  localparam int ERR_W    = 4;

  localparam logic [1:0] VEC_ORDER [NUM_VECS] = '{2'b00, 2'b01, 2'b10, 2'b11};

  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    return VEC_ORDER[idx];
  endfunction

endpackage

// File: rtl/gor_ex_timer.sv
// gor_ex_timer: hold counter that paces how long each vector stays on the gate.
// Counts 0..HOLD_CYCLES-1 while en is high and wraps back to 0.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear to 0 (has priority over en)
//   en    : advance the count
//   last  : count is at HOLD_CYCLES-1 (final cycle of the current vector)
module gor_ex_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [7:0] cnt;

  assign last = (cnt == 8'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= last ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/gor_exerciser.sv
// gor_exerciser: synthesizable stimulus-and-check sequencer for a 2-input OR gate.
// Sweeps {a,b} through 00,01,10,11 NUM_PASSES times, each vector held for
// HOLD_CYCLES cycles, and checks the gate output c against a|b on the last
// cycle of each vector.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   start      : begin a run (honoured only in IDLE or DONE)
//   c          : gate output under test
//   a, b       : registered drive to the gate inputs
//   busy       : run in progress
//   done       : run finished; holds until next accepted start or reset
//   pass       : done with zero mismatches
//   err_count  : saturating mismatch count of the current/last run
//   first_fail : {a,b} of the first mismatch, 0 if none
module gor_exerciser
  import gor_ex_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_PASSES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t     state, state_next;
  logic [1:0] vec_idx;
  logic [3:0] pass_cnt;
  logic       hold_last;
  logic       accept;
  logic       step;
  logic       finish;

  gor_ex_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == RUN),
    .last  (hold_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // step: the edge that samples c and moves to the next vector.
  // finish: that edge is also the last one of the last pass.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (hold_last) begin
          step = 1'b1;
          if (vec_idx == 2'(NUM_VECS - 1) && pass_cnt == 4'(NUM_PASSES - 1)) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // the state register itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {a, b}     <= 2'b00;
      vec_idx    <= 2'd0;
      pass_cnt   <= 4'd0;
      err_count  <= '0;
      first_fail <= 2'b00;
    end else if (accept) begin
      {a, b}     <= vec_at(2'd0);
      vec_idx    <= 2'd0;
      pass_cnt   <= 4'd0;
      err_count  <= '0;
      first_fail <= 2'b00;
    end else if (step) begin
      if (c != (a | b)) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + 1'b1;
        end
        // A zero count means no mismatch has been seen yet in this run.
        if (err_count == '0) begin
          first_fail <= {a, b};
        end
      end
      vec_idx <= vec_idx + 2'd1;
      if (vec_idx == 2'(NUM_VECS - 1)) begin
        pass_cnt <= pass_cnt + 4'd1;
      end
      {a, b} <= finish ? 2'b00 : vec_at(vec_idx + 2'd1);
    end
  end

  assign pass = done && (err_count == '0);

endmodule
